// File: rtl/imem_loader.sv
// Boot-time program loader: unpacks a framed byte stream into 32-bit instruction
// words, writes them into instruction memory, and holds the core until the image checks out.
module imem_loader #(
   parameter int unsigned ADDR_W        = 8,
   parameter int unsigned DEPTH         = 256,
   parameter bit          HOLD_AT_RESET = 1'b1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              s_valid,
   input  logic [7:0]        s_data,
   output logic              s_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              core_hold,
   output logic              busy,
   output logic              done,
   output logic              err_len,
   output logic              err_csum
);

   localparam int unsigned IDX_W = ADDR_W + 1;

   typedef enum logic [2:0] {
      S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_DONE, S_ERROR
   } state_t;

   state_t             r_state,      w_state_nxt;
   logic [7:0]         r_len_lo,     w_len_lo_nxt;
   logic [IDX_W-1:0]   r_len,        w_len_nxt;
   logic [IDX_W-1:0]   r_idx,        w_idx_nxt;
   logic [1:0]         r_bcnt,       w_bcnt_nxt;
   logic [23:0]        r_asm,        w_asm_nxt;
   logic [7:0]         r_xor,        w_xor_nxt;
   logic               r_wr,         w_wr_nxt;
   logic               r_s_ready,    w_s_ready_nxt;
   logic               r_imem_we,    w_imem_we_nxt;
   logic [ADDR_W-1:0]  r_imem_addr,  w_imem_addr_nxt;
   logic [31:0]        r_imem_wdata, w_imem_wdata_nxt;
   logic               r_core_hold,  w_core_hold_nxt;
   logic               r_busy,       w_busy_nxt;
   logic               r_done,       w_done_nxt;
   logic               r_err_len,    w_err_len_nxt;
   logic               r_err_csum,   w_err_csum_nxt;

   logic               w_xfer;
   logic [15:0]        w_len16;

   assign w_xfer  = s_valid && r_s_ready;
   assign w_len16 = {s_data, r_len_lo};

   // State and datapath registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= S_IDLE;
         r_len_lo     <= '0;
         r_len        <= '0;
         r_idx        <= '0;
         r_bcnt       <= '0;
         r_asm        <= '0;
         r_xor        <= '0;
         r_wr         <= 1'b0;
         r_s_ready    <= 1'b0;
         r_imem_we    <= 1'b0;
         r_imem_addr  <= '0;
         r_imem_wdata <= '0;
         r_core_hold  <= HOLD_AT_RESET;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_err_len    <= 1'b0;
         r_err_csum   <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_len_lo     <= w_len_lo_nxt;
         r_len        <= w_len_nxt;
         r_idx        <= w_idx_nxt;
         r_bcnt       <= w_bcnt_nxt;
         r_asm        <= w_asm_nxt;
         r_xor        <= w_xor_nxt;
         r_wr         <= w_wr_nxt;
         r_s_ready    <= w_s_ready_nxt;
         r_imem_we    <= w_imem_we_nxt;
         r_imem_addr  <= w_imem_addr_nxt;
         r_imem_wdata <= w_imem_wdata_nxt;
         r_core_hold  <= w_core_hold_nxt;
         r_busy       <= w_busy_nxt;
         r_done       <= w_done_nxt;
         r_err_len    <= w_err_len_nxt;
         r_err_csum   <= w_err_csum_nxt;
      end
   end

   // Next-state and next-output logic; outputs are computed one cycle ahead so they leave registered
   always_comb begin
      w_state_nxt      = r_state;
      w_len_lo_nxt     = r_len_lo;
      w_len_nxt        = r_len;
      w_idx_nxt        = r_idx;
      w_bcnt_nxt       = r_bcnt;
      w_asm_nxt        = r_asm;
      w_xor_nxt        = r_xor;
      w_wr_nxt         = r_wr;
      w_s_ready_nxt    = r_s_ready;
      w_imem_we_nxt    = 1'b0;
      w_imem_addr_nxt  = r_imem_addr;
      w_imem_wdata_nxt = r_imem_wdata;
      w_core_hold_nxt  = r_core_hold;
      w_busy_nxt       = r_busy;
      w_done_nxt       = r_done;
      w_err_len_nxt    = r_err_len;
      w_err_csum_nxt   = r_err_csum;

      case (r_state)
         S_IDLE, S_DONE, S_ERROR: begin
            if (start) begin
               w_state_nxt     = S_LEN_LO;
               w_done_nxt      = 1'b0;
               w_err_len_nxt   = 1'b0;
               w_err_csum_nxt  = 1'b0;
               w_core_hold_nxt = 1'b1;
               w_idx_nxt       = '0;
               w_xor_nxt       = '0;
               w_bcnt_nxt      = '0;
               w_wr_nxt        = 1'b0;
               w_s_ready_nxt   = 1'b1;
               w_busy_nxt      = 1'b1;
            end
         end

         S_LEN_LO: begin
            if (w_xfer) begin
               w_len_lo_nxt = s_data;
               w_state_nxt  = S_LEN_HI;
            end
         end

         S_LEN_HI: begin
            if (w_xfer) begin
               if (32'(w_len16) > DEPTH) begin
                  w_state_nxt   = S_ERROR;
                  w_err_len_nxt = 1'b1;
                  w_s_ready_nxt = 1'b0;
                  w_busy_nxt    = 1'b0;
               end else if (w_len16 == 16'h0000) begin
                  w_len_nxt   = '0;
                  w_state_nxt = S_CSUM;
               end else begin
                  w_len_nxt   = IDX_W'(w_len16);
                  w_state_nxt = S_DATA;
               end
            end
         end

         S_DATA: begin
            // r_wr marks the single write cycle, during which no byte is taken
            if (r_wr) begin
               w_wr_nxt      = 1'b0;
               w_s_ready_nxt = 1'b1;
               if (r_idx == r_len) begin
                  w_state_nxt = S_CSUM;
               end
            end else if (w_xfer) begin
               w_asm_nxt  = {s_data, r_asm[23:8]};
               w_xor_nxt  = r_xor ^ s_data;
               w_bcnt_nxt = r_bcnt + 2'd1;
               if (r_bcnt == 2'd3) begin
                  w_imem_we_nxt    = 1'b1;
                  w_imem_addr_nxt  = ADDR_W'(r_idx);
                  w_imem_wdata_nxt = {s_data, r_asm};
                  w_idx_nxt        = r_idx + IDX_W'(1);
                  w_wr_nxt         = 1'b1;
                  w_s_ready_nxt    = 1'b0;
               end
            end
         end

         S_CSUM: begin
            if (w_xfer) begin
               w_s_ready_nxt = 1'b0;
               w_busy_nxt    = 1'b0;
               if (s_data == r_xor) begin
                  w_state_nxt     = S_DONE;
                  w_done_nxt      = 1'b1;
                  w_core_hold_nxt = 1'b0;
               end else begin
                  w_state_nxt    = S_ERROR;
                  w_err_csum_nxt = 1'b1;
               end
            end
         end

         default: begin
            w_state_nxt   = S_IDLE;
            w_s_ready_nxt = 1'b0;
            w_busy_nxt    = 1'b0;
         end
      endcase
   end

   assign s_ready    = r_s_ready;
   assign imem_we    = r_imem_we;
   assign imem_addr  = r_imem_addr;
   assign imem_wdata = r_imem_wdata;
   assign core_hold  = r_core_hold;
   assign busy       = r_busy;
   assign done       = r_done;
   assign err_len    = r_err_len;
   assign err_csum   = r_err_csum;

endmodule
